// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one main-memory port between the icache (read refills) and the
// dcache (refills and write-backs). One transaction in flight, alternating grants on
// contention, with a watchdog that force-completes a transaction on a stuck memory.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLOCK,
  input  logic              RESET,
  // icache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  // dcache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic              timeout_err
);

  typedef enum logic [1:0] {StIdle, StGrantD, StGrantI, StRelease} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e            state;
  logic              owner_d;  // 1: dcache owns the bus, 0: icache
  logic              last_d;   // owner of the most recently completed transaction
  logic [7:0]        cnt;
  logic              d_req, i_req, pick_d;
  logic              done_ok, done_tmo;
  logic [DATA_W-1:0] rd_data;

  // Request decode, arbitration choice and completion detection.
  always_comb begin
    d_req    = d_read | d_write;
    i_req    = i_read;
    // Contention goes to whoever did not complete last.
    pick_d   = d_req & (~i_req | ~last_d);
    // Memory finishing on the timeout edge still counts as a normal completion.
    done_ok  = (cnt != 8'd0) & ~mem_busywait;
    done_tmo = (cnt == TimeoutCnt) & ~done_ok;
    rd_data  = done_ok ? mem_readdata : '0;
  end

  // Stall each cache except during the release cycle of its own completed transaction.
  always_comb begin
    i_busywait = RESET & i_req & ~((state == StRelease) & ~owner_d);
    d_busywait = RESET & d_req & ~((state == StRelease) & owner_d);
  end

  // Arbiter FSM with registered memory strobes, return data and watchdog flag.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state         <= StIdle;
      owner_d       <= 1'b0;
      last_d        <= 1'b0;
      cnt           <= 8'd0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
      timeout_err   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (d_req | i_req) begin
            owner_d <= pick_d;
            cnt     <= 8'd0;
            if (pick_d) begin
              state         <= StGrantD;
              mem_address   <= d_address;
              mem_writedata <= d_writedata;
              mem_write     <= d_write;
              mem_read      <= d_read & ~d_write;  // write-back wins over refill
            end else begin
              state         <= StGrantI;
              mem_address   <= i_address;
              mem_writedata <= '0;
              mem_write     <= 1'b0;
              mem_read      <= 1'b1;
            end
          end
        end
        StGrantD, StGrantI: begin
          if (done_ok | done_tmo) begin
            if (mem_read) begin
              if (owner_d) d_readdata <= rd_data;
              else         i_readdata <= rd_data;
            end
            if (done_tmo) timeout_err <= 1'b1;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            last_d      <= owner_d;
            state       <= StRelease;
          end else if (cnt != TimeoutCnt) begin
            cnt <= cnt + 8'd1;
          end
        end
        StRelease: state <= StIdle;
        default:   state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a transaction-level model plus a latency-programmable memory,
// checked against the DUT on every falling edge, with directed scenarios and literal checks.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;
  logic          mem_busywait = 1'b0;
  logic          timeout_err;

  always #5 CLOCK = ~CLOCK;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: one transaction record plus a release marker ----------------
  bit            busy = 0, rel = 0, own_d = 0, rel_d = 0, last_d = 0;
  bit            m_rd = 0, m_wr = 0, terr = 0, ok = 0, tmo = 0, fresh = 0;
  int            age = 0, mcnt = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, e_ird = '0, e_drd = '0, v = '0;
  logic [DW-1:0] mem [64];
  int            lat = 0;   // memory busy cycles after a strobe appears
  bit            stuck = 0; // memory never answers

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[5] = 32'hDEAD_BEEF;
  end

  always @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      busy = 0; rel = 0; own_d = 0; rel_d = 0; last_d = 0;
      m_rd = 0; m_wr = 0; terr = 0; age = 0; m_addr = '0; m_wdata = '0;
      e_ird = '0; e_drd = '0;
      mem_busywait <= 1'b0;
      mem_readdata <= '0;
    end else begin
      fresh = 0;
      if (rel) begin
        rel = 0;
      end else if (busy) begin
        ok  = (age >= 1) && !mem_busywait;
        tmo = !ok && (age == TO);
        if (ok || tmo) begin
          v = ok ? mem_readdata : '0;
          if (m_rd) begin
            if (own_d) e_drd = v;
            else       e_ird = v;
          end
          if (m_wr && ok) mem[m_addr] = m_wdata;
          if (tmo) terr = 1;
          busy = 0; rel = 1; rel_d = own_d; last_d = own_d;
          m_rd = 0; m_wr = 0; m_addr = '0;
        end else if (age < TO) begin
          age++;
        end
      end else if (d_read || d_write || i_read) begin
        own_d = (d_read || d_write) && (!i_read || !last_d);
        if (own_d) begin
          m_addr = d_address; m_wdata = d_writedata; m_wr = d_write; m_rd = d_read && !d_write;
        end else begin
          m_addr = i_address; m_wdata = '0; m_wr = 0; m_rd = 1;
        end
        busy = 1; age = 0; mcnt = 0; fresh = 1;
      end
      // memory responder
      if (busy) begin
        if (!fresh) mcnt++;
        mem_busywait <= stuck || (mcnt < lat);
        mem_readdata <= mem[m_addr];
      end else begin
        mem_busywait <= 1'b0;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge CLOCK) begin
    check("mem_read", 32'(mem_read), 32'(m_rd));
    check("mem_write", 32'(mem_write), 32'(m_wr));
    check("mem_address", 32'(mem_address), 32'(m_addr));
    check("mem_writedata", mem_writedata, m_wdata);
    check("i_readdata", i_readdata, e_ird);
    check("d_readdata", d_readdata, e_drd);
    check("i_busywait", 32'(i_busywait), 32'(RESET && i_read && !(rel && !rel_d)));
    check("d_busywait", 32'(d_busywait),
          32'(RESET && (d_read || d_write) && !(rel && rel_d)));
    check("timeout_err", 32'(timeout_err), 32'(terr));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(negedge CLOCK); #1; end
  endtask

  // Cycles until the memory strobe reaches the given level, bounded.
  task automatic wait_strobe(input bit level, output int n);
    n = 0;
    do begin
      @(negedge CLOCK); #1; n++;
    end while (((mem_read | mem_write) !== level) && n < 100);
    if ((mem_read | mem_write) !== level) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_strobe: level %0b not seen within %0d cycles", level, n);
    end
  endtask

  task automatic apply_reset();
    RESET = 1'b0;
    tick(2);
    RESET = 1'b1;
  endtask

  int n;
  logic [AW-1:0] exp_addr;

  initial begin
    #1 RESET = 1'b0;
    tick(2);
    check("reset mem_read", 32'(mem_read), 0);
    check("reset i_readdata", i_readdata, 0);
    check("reset d_busywait", 32'(d_busywait), 0);
    RESET = 1'b1;
    tick(1);

    // icache-only read, 4 busy cycles
    lat = 4; i_address = 6'h05; i_read = 1;
    wait_strobe(1, n);
    check("ic grant addr", 32'(mem_address), 32'h05);
    check("ic grant read", 32'(mem_read), 1);
    wait_strobe(0, n);
    check("ic grant length", 32'(n), 5);
    check("ic readdata", i_readdata, 32'hDEAD_BEEF);
    check("ic release busywait", 32'(i_busywait), 0);
    check("ic d_busywait", 32'(d_busywait), 0);
    i_read = 0;
    tick(2);

    // contention after reset: dcache first
    apply_reset();
    lat = 2; d_read = 1; d_address = 6'h10; i_read = 1; i_address = 6'h20;
    wait_strobe(1, n);
    check("cont first addr", 32'(mem_address), 32'h10);
    check("cont icache stalled", 32'(i_busywait), 1);
    wait_strobe(0, n);
    check("cont gap addr", 32'(mem_address), 0);
    d_read = 0;
    wait_strobe(1, n);
    check("cont second addr", 32'(mem_address), 32'h20);
    wait_strobe(0, n);
    i_read = 0;
    check("cont d_readdata", d_readdata, 32'hC0DE_0010);
    check("cont i_readdata", i_readdata, 32'hC0DE_0020);
    tick(2);

    // dcache write-back, inputs change mid-grant
    lat = 3; d_write = 1; d_address = 6'h3F; d_writedata = 32'hA5A5_0F0F;
    wait_strobe(1, n);
    check("wb mem_write", 32'(mem_write), 1);
    check("wb mem_read", 32'(mem_read), 0);
    d_address = 6'h01; d_writedata = 32'h0;
    tick(1);
    check("wb held addr", 32'(mem_address), 32'h3F);
    check("wb held data", mem_writedata, 32'hA5A5_0F0F);
    wait_strobe(0, n);
    d_write = 0;
    check("wb d_readdata kept", d_readdata, 32'hC0DE_0010);
    tick(1);
    lat = 1; d_read = 1; d_address = 6'h3F;
    wait_strobe(1, n);
    wait_strobe(0, n);
    d_read = 0;
    check("wb readback", d_readdata, 32'hA5A5_0F0F);
    tick(2);

    // continuous contention, six transactions
    apply_reset();
    lat = 1; d_read = 1; d_address = 6'h11; i_read = 1; i_address = 6'h22;
    for (int k = 0; k < 6; k++) begin
      wait_strobe(1, n);
      if (k > 0) check("alt gap", 32'(n), 2);
      exp_addr = (k % 2 == 0) ? 6'h11 : 6'h22;
      check("alt order", 32'(mem_address), 32'(exp_addr));
      wait_strobe(0, n);
    end
    d_read = 0; i_read = 0;
    tick(2);

    // watchdog on a stuck memory
    stuck = 1; i_read = 1; i_address = 6'h07;
    wait_strobe(1, n);
    wait_strobe(0, n);
    check("wd grant length", 32'(n), TO + 1);
    check("wd readdata zero", i_readdata, 0);
    check("wd flag", 32'(timeout_err), 1);
    i_read = 0; stuck = 0;
    tick(1);
    lat = 0; i_read = 1; i_address = 6'h05;
    wait_strobe(1, n);
    wait_strobe(0, n);
    i_read = 0;
    check("wd next read", i_readdata, 32'hDEAD_BEEF);
    check("wd flag sticky", 32'(timeout_err), 1);
    tick(2);

    // reset in the middle of a dcache read
    lat = 10; d_read = 1; d_address = 6'h2A;
    wait_strobe(1, n);
    @(posedge CLOCK); @(posedge CLOCK); #2;
    RESET = 1'b0;
    #1;
    check("mid rst mem_read", 32'(mem_read), 0);
    check("mid rst mem_address", 32'(mem_address), 0);
    check("mid rst timeout_err", 32'(timeout_err), 0);
    check("mid rst i_readdata", i_readdata, 0);
    check("mid rst d_busywait", 32'(d_busywait), 0);
    tick(2);
    RESET = 1'b1; lat = 1;
    wait_strobe(1, n);
    check("regrant after reset", 32'(n), 1);
    check("regrant addr", 32'(mem_address), 32'h2A);
    wait_strobe(0, n);
    d_read = 0;
    check("regrant data", d_readdata, 32'hC0DE_002A);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
